t_ff_bank: RTL and testbench
============================

Name: t_ff_bank

Overview:
- Parametrised multi-channel T flip-flop bank, WIDTH independent toggle channels sharing one clock.
- Adds to a single T storage element:
  - level or rising-edge toggle mode;
  - parallel load, clear and hold operations;
  - a change-flag pulse;
  - a saturating or wrapping change-event counter.
- Intended as the general toggle-register primitive for divider, parity and status-bit logic.

Parameters:
- WIDTH, 4, number of toggle channels (≥1).
- EDGE_MODE, 0, 0 = toggle on T level each enabled cycle; 1 = toggle only on T rising edge (0→1 across consecutive clocks).
- RESET_VAL, 0, WIDTH-bit value loaded into q on reset and on clear.
- CNT_W, 4, width of change-event counter.
- CNT_WRAP, 0, 0 = counter saturates at all-ones; 1 = counter wraps to 0.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset: reset==0 at a rising clk edge resets the block.
- en  input  1  global enable; 0 freezes q and tog_cnt.
- mode  input  2  00 toggle, 01 load d, 10 clear to RESET_VAL, 11 hold.
- t  input  WIDTH  per-channel toggle request.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  registered channel state.
- qn  output  WIDTH  always exactly ~q (combinational from q).
- changed  output  1  registered; 1 for one cycle after any q bit changed.
- tog_cnt  output  CNT_W  count of clock edges at which q changed.

Behaviour:
- Reset: if reset==0 at a clk edge, the following values are set and take priority over en/mode/t/d:
  - q = RESET_VAL, qn = ~RESET_VAL;
  - changed = 0, tog_cnt = 0;
  - internal t_prev = 0.
- Deasserting reset mid-operation takes effect at the next edge. There is no async path; reset asserted between edges does nothing until the next edge.
- t_prev <= t on every non-reset edge, regardless of en/mode. Edges that occur while disabled or in a non-toggle mode are consumed and never fire later.
- Effective toggle vector tv:
  - EDGE_MODE=0: tv = t.
  - EDGE_MODE=1: tv = t & ~t_prev.
- Next-state q_nxt when en==1:
  - mode 00: q ^ tv;
  - mode 01: d;
  - mode 10: RESET_VAL;
  - mode 11: q.
- When en==0: q_nxt = q.
- Latency: q updates at the edge where inputs are sampled; qn follows q in the same cycle.
- changed <= (q_nxt != q). Load or clear of an identical value gives changed=0. changed is 0 whenever en==0.
- tog_cnt increments by exactly 1 on each edge where q_nxt != q, independent of how many bits flip.
- At all-ones:
  - CNT_WRAP=0: tog_cnt holds at all-ones;
  - CNT_WRAP=1: tog_cnt goes to 0.
- Width rules:
  - tog_cnt is unsigned CNT_W bits.
  - No truncation of q/d/t; all are WIDTH bits.
  - RESET_VAL is truncated/zero-extended to WIDTH.
- Simultaneous events:
  - reset beats everything;
  - mode beats t (e.g. load with t asserted loads d; t is ignored apart from t_prev update).
- No X propagation allowed: all outputs are defined from the first reset edge.

Test Plan (WIDTH=4, CNT_W=4 unless stated):
- Reset: hold reset=0 for 2 edges with t=4'hF, mode=00, en=1 → q=4'h0, qn=4'hF, changed=0, tog_cnt=0. Release reset → next edge q=4'hF, changed=1 next cycle, tog_cnt=1.
- Level toggle (EDGE_MODE=0): t=4'b0101 held 3 edges, mode=00, en=1 from q=0 → q sequence 0101, 0000, 0101; tog_cnt=3.
- Edge toggle (EDGE_MODE=1): t rises to 4'b0011 and stays high 3 edges → q=0011 after first edge only, then stable; tog_cnt=1. Drop t to 0 and raise again → q=0000.
- Enable and edge consumption (EDGE_MODE=1): en=0 while t rises 0→4'h1, then en=1 with t held → q unchanged, changed=0, tog_cnt unchanged.
- Modes:
  - load d=4'hA with t=4'hF → q=4'hA, qn=4'h5;
  - load 4'hA again → changed=0, tog_cnt unchanged;
  - clear → q=RESET_VAL;
  - hold with t=4'hF → q unchanged.
- Counter limits: force 20 changing edges.
  - CNT_WRAP=0 → tog_cnt stops at 4'hF.
  - CNT_WRAP=1 → tog_cnt=4 (20 mod 16).
  - Assert reset mid-count → tog_cnt=0 at that edge.

Source files
------------

// File: rtl/t_ff_bank.sv
// Multi-channel T flip-flop bank: level/edge toggle, load/clear/hold,
// a one-cycle change flag and a saturating or wrapping change counter.
module t_ff_bank #(
   parameter int              WIDTH     = 4,
   parameter int              EDGE_MODE = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int              CNT_W     = 4,
   parameter int              CNT_WRAP  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             changed,
   output logic [CNT_W-1:0] tog_cnt
);

   localparam logic [1:0] MODE_TOG   = 2'b00;
   localparam logic [1:0] MODE_LOAD  = 2'b01;
   localparam logic [1:0] MODE_CLEAR = 2'b10;
   localparam logic [1:0] MODE_HOLD  = 2'b11;

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] t_prev_q, t_prev_d;
   logic             changed_q, changed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] tv;

   always_comb begin
      // Edge mode only fires on a 0->1 seen across consecutive edges.
      tv = (EDGE_MODE != 0) ? (t & ~t_prev_q) : t;
      t_prev_d = t;

      q_d = q_q;
      if (en) begin
         case (mode)
            MODE_TOG:   q_d = q_q ^ tv;
            MODE_LOAD:  q_d = d;
            MODE_CLEAR: q_d = RESET_VAL;
            MODE_HOLD:  q_d = q_q;
            default:    q_d = q_q;
         endcase
      end

      changed_d = (q_d != q_q);

      cnt_d = cnt_q;
      if (changed_d) begin
         if (cnt_q == {CNT_W{1'b1}})
            cnt_d = (CNT_WRAP != 0) ? '0 : cnt_q;
         else
            cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q       <= RESET_VAL;
         t_prev_q  <= '0;
         changed_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         q_q       <= q_d;
         t_prev_q  <= t_prev_d;
         changed_q <= changed_d;
         cnt_q     <= cnt_d;
      end
   end

   assign q       = q_q;
   assign qn      = ~q_q;
   assign changed = changed_q;
   assign tog_cnt = cnt_q;

endmodule

// File: tb/tb_t_ff_bank.sv
// Directed bench for t_ff_bank: three instances (level/saturate, edge/saturate,
// level/wrap with non-zero reset value) driven from one shared stimulus.
module tb_t_ff_bank;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [1:0] mode;
   logic [3:0] t;
   logic [3:0] d;

   logic [3:0] q_l, qn_l, cnt_l;
   logic       ch_l;
   logic [3:0] q_e, qn_e, cnt_e;
   logic       ch_e;
   logic [3:0] q_w, qn_w, cnt_w;
   logic       ch_w;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   t_ff_bank #(.WIDTH(4), .EDGE_MODE(0), .RESET_VAL(4'h0), .CNT_W(4), .CNT_WRAP(0)) u_lvl (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .d(d),
      .q(q_l), .qn(qn_l), .changed(ch_l), .tog_cnt(cnt_l));

   t_ff_bank #(.WIDTH(4), .EDGE_MODE(1), .RESET_VAL(4'h0), .CNT_W(4), .CNT_WRAP(0)) u_edge (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .d(d),
      .q(q_e), .qn(qn_e), .changed(ch_e), .tog_cnt(cnt_e));

   t_ff_bank #(.WIDTH(4), .EDGE_MODE(0), .RESET_VAL(4'h6), .CNT_W(4), .CNT_WRAP(1)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .d(d),
      .q(q_w), .qn(qn_w), .changed(ch_w), .tog_cnt(cnt_w));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; en = 1'b1; mode = 2'b00; t = 4'h0; d = 4'h0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b1; mode = 2'b00; t = 4'hF; d = 4'h0;
      tick(); tick();
      chk_cnt++; if (q_l !== 4'h0) $display("FAIL reset_q got=%h exp=0", q_l); else pass_cnt++;
      chk_cnt++; if (qn_l !== 4'hF) $display("FAIL reset_qn got=%h exp=f", qn_l); else pass_cnt++;
      chk_cnt++; if (ch_l !== 1'b0) $display("FAIL reset_changed got=%b exp=0", ch_l); else pass_cnt++;
      chk_cnt++; if (cnt_l !== 4'h0) $display("FAIL reset_cnt got=%h exp=0", cnt_l); else pass_cnt++;
      chk_cnt++; if (q_w !== 4'h6) $display("FAIL reset_val_q got=%h exp=6", q_w); else pass_cnt++;
      reset = 1'b1;
      tick();
      chk_cnt++; if (q_l !== 4'hF) $display("FAIL release_q got=%h exp=f", q_l); else pass_cnt++;
      chk_cnt++; if (ch_l !== 1'b1) $display("FAIL release_changed got=%b exp=1", ch_l); else pass_cnt++;
      chk_cnt++; if (cnt_l !== 4'h1) $display("FAIL release_cnt got=%h exp=1", cnt_l); else pass_cnt++;
      chk_cnt++; if (q_w !== 4'h9) $display("FAIL release_wrap_q got=%h exp=9", q_w); else pass_cnt++;
   endtask

   task automatic test_level_toggle();
      logic [3:0] exp_q [3];
      exp_q[0] = 4'b0101; exp_q[1] = 4'b0000; exp_q[2] = 4'b0101;
      do_reset();
      t = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_cnt++; if (q_l !== exp_q[i]) $display("FAIL level_q[%0d] got=%b exp=%b", i, q_l, exp_q[i]); else pass_cnt++;
      end
      chk_cnt++; if (cnt_l !== 4'h3) $display("FAIL level_cnt got=%h exp=3", cnt_l); else pass_cnt++;
      chk_cnt++; if (qn_l !== 4'b1010) $display("FAIL level_qn got=%b exp=1010", qn_l); else pass_cnt++;
   endtask

   task automatic test_edge_toggle();
      do_reset();
      t = 4'h0;
      tick();
      t = 4'b0011;
      tick();
      chk_cnt++; if (q_e !== 4'b0011) $display("FAIL edge_first_q got=%b exp=0011", q_e); else pass_cnt++;
      chk_cnt++; if (ch_e !== 1'b1) $display("FAIL edge_first_changed got=%b exp=1", ch_e); else pass_cnt++;
      tick(); tick();
      chk_cnt++; if (q_e !== 4'b0011) $display("FAIL edge_held_q got=%b exp=0011", q_e); else pass_cnt++;
      chk_cnt++; if (ch_e !== 1'b0) $display("FAIL edge_held_changed got=%b exp=0", ch_e); else pass_cnt++;
      chk_cnt++; if (cnt_e !== 4'h1) $display("FAIL edge_held_cnt got=%h exp=1", cnt_e); else pass_cnt++;
      t = 4'h0;
      tick();
      chk_cnt++; if (q_e !== 4'b0011) $display("FAIL edge_fall_q got=%b exp=0011", q_e); else pass_cnt++;
      t = 4'b0011;
      tick();
      chk_cnt++; if (q_e !== 4'b0000) $display("FAIL edge_rerise_q got=%b exp=0000", q_e); else pass_cnt++;
      chk_cnt++; if (cnt_e !== 4'h2) $display("FAIL edge_rerise_cnt got=%h exp=2", cnt_e); else pass_cnt++;
   endtask

   task automatic test_enable_consume();
      do_reset();
      en = 1'b0; t = 4'h0;
      tick();
      t = 4'h1;
      tick();
      chk_cnt++; if (q_e !== 4'h0) $display("FAIL en0_q got=%h exp=0", q_e); else pass_cnt++;
      chk_cnt++; if (ch_l !== 1'b0) $display("FAIL en0_changed got=%b exp=0", ch_l); else pass_cnt++;
      chk_cnt++; if (q_l !== 4'h0) $display("FAIL en0_level_q got=%h exp=0", q_l); else pass_cnt++;
      en = 1'b1;
      tick();
      chk_cnt++; if (q_e !== 4'h0) $display("FAIL consumed_q got=%h exp=0", q_e); else pass_cnt++;
      chk_cnt++; if (ch_e !== 1'b0) $display("FAIL consumed_changed got=%b exp=0", ch_e); else pass_cnt++;
      chk_cnt++; if (cnt_e !== 4'h0) $display("FAIL consumed_cnt got=%h exp=0", cnt_e); else pass_cnt++;
      chk_cnt++; if (q_l !== 4'h1) $display("FAIL en1_level_q got=%h exp=1", q_l); else pass_cnt++;
   endtask

   task automatic test_modes();
      do_reset();
      mode = 2'b01; d = 4'hA; t = 4'hF;
      tick();
      chk_cnt++; if (q_l !== 4'hA) $display("FAIL load_q got=%h exp=a", q_l); else pass_cnt++;
      chk_cnt++; if (qn_l !== 4'h5) $display("FAIL load_qn got=%h exp=5", qn_l); else pass_cnt++;
      chk_cnt++; if (cnt_l !== 4'h1) $display("FAIL load_cnt got=%h exp=1", cnt_l); else pass_cnt++;
      tick();
      chk_cnt++; if (ch_l !== 1'b0) $display("FAIL reload_changed got=%b exp=0", ch_l); else pass_cnt++;
      chk_cnt++; if (cnt_l !== 4'h1) $display("FAIL reload_cnt got=%h exp=1", cnt_l); else pass_cnt++;
      mode = 2'b10;
      tick();
      chk_cnt++; if (q_l !== 4'h0) $display("FAIL clear_q got=%h exp=0", q_l); else pass_cnt++;
      chk_cnt++; if (cnt_l !== 4'h2) $display("FAIL clear_cnt got=%h exp=2", cnt_l); else pass_cnt++;
      chk_cnt++; if (q_w !== 4'h6) $display("FAIL clear_resetval_q got=%h exp=6", q_w); else pass_cnt++;
      chk_cnt++; if (ch_w !== 1'b1) $display("FAIL clear_resetval_changed got=%b exp=1", ch_w); else pass_cnt++;
      tick();
      chk_cnt++; if (ch_l !== 1'b0) $display("FAIL reclear_changed got=%b exp=0", ch_l); else pass_cnt++;
      mode = 2'b00;
      tick();
      chk_cnt++; if (q_l !== 4'hF) $display("FAIL tog_after_clear_q got=%h exp=f", q_l); else pass_cnt++;
      mode = 2'b11;
      tick();
      chk_cnt++; if (q_l !== 4'hF) $display("FAIL hold_q got=%h exp=f", q_l); else pass_cnt++;
      chk_cnt++; if (ch_l !== 1'b0) $display("FAIL hold_changed got=%b exp=0", ch_l); else pass_cnt++;
      chk_cnt++; if (cnt_l !== 4'h3) $display("FAIL hold_cnt got=%h exp=3", cnt_l); else pass_cnt++;
   endtask

   task automatic test_counter_limits();
      do_reset();
      mode = 2'b00; t = 4'h1;
      for (int i = 0; i < 15; i++) tick();
      chk_cnt++; if (cnt_l !== 4'hF) $display("FAIL cnt15_sat got=%h exp=f", cnt_l); else pass_cnt++;
      chk_cnt++; if (cnt_w !== 4'hF) $display("FAIL cnt15_wrap got=%h exp=f", cnt_w); else pass_cnt++;
      tick();
      chk_cnt++; if (cnt_l !== 4'hF) $display("FAIL cnt16_sat got=%h exp=f", cnt_l); else pass_cnt++;
      chk_cnt++; if (cnt_w !== 4'h0) $display("FAIL cnt16_wrap got=%h exp=0", cnt_w); else pass_cnt++;
      for (int i = 0; i < 4; i++) tick();
      chk_cnt++; if (cnt_l !== 4'hF) $display("FAIL cnt20_sat got=%h exp=f", cnt_l); else pass_cnt++;
      chk_cnt++; if (cnt_w !== 4'h4) $display("FAIL cnt20_wrap got=%h exp=4", cnt_w); else pass_cnt++;
      for (int i = 0; i < 3; i++) tick();
      chk_cnt++; if (cnt_w !== 4'h7) $display("FAIL cnt23_wrap got=%h exp=7", cnt_w); else pass_cnt++;
      reset = 1'b0;
      tick();
      chk_cnt++; if (cnt_w !== 4'h0) $display("FAIL midreset_wrap_cnt got=%h exp=0", cnt_w); else pass_cnt++;
      chk_cnt++; if (cnt_l !== 4'h0) $display("FAIL midreset_sat_cnt got=%h exp=0", cnt_l); else pass_cnt++;
      chk_cnt++; if (q_w !== 4'h6) $display("FAIL midreset_q got=%h exp=6", q_w); else pass_cnt++;
      chk_cnt++; if (ch_w !== 1'b0) $display("FAIL midreset_changed got=%b exp=0", ch_w); else pass_cnt++;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; mode = 2'b00; t = 4'h0; d = 4'h0;
      test_reset();
      test_level_toggle();
      test_edge_toggle();
      test_enable_consume();
      test_modes();
      test_counter_limits();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
